// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller for a five-stage RV32I pipeline: tracks in-flight writers
// in a three-entry scoreboard and derives stall/flush/bubble enables plus operand forwarding.
module pipeline_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             reg_write,
  input  logic             load,
  input  logic             store,
  input  logic             redirect,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_valid,
  output logic             ex_bubble,
  output logic             stage_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] StRun       = 2'd0;
  localparam logic [1:0] StLoadStall = 2'd1;
  localparam logic [1:0] StFlush     = 2'd2;
  localparam logic [1:0] StMemWait   = 2'd3;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       st;
  } sb_entry_t;

  sb_entry_t        ex_q, mem_q, wb_q;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_wait, flush, ex_hit, load_stall;

  function automatic logic match(input sb_entry_t e, input logic [4:0] src, input logic use_src);
    return e.v & e.we & (e.rd != 5'd0) & use_src & (e.rd == src);
  endfunction

  // Youngest producer wins; a load in EX has no result yet, so it never forwards from EX.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic use_src,
                                         input sb_entry_t ex, input sb_entry_t mem,
                                         input sb_entry_t wb);
    if (match(ex, src, use_src) && !ex.ld) return 2'b01;
    else if (match(mem, src, use_src))     return 2'b10;
    else if (match(wb, src, use_src))      return 2'b11;
    else                                   return 2'b00;
  endfunction

  assign mem_wait   = mem_q.v & (mem_q.ld | mem_q.st) & ~mem_ready;
  assign flush      = redirect & ex_q.v;
  assign ex_hit     = match(ex_q, rs1, uses_rs1) | match(ex_q, rs2, uses_rs2);
  assign load_stall = id_valid_q & ex_q.ld & ex_hit;

  always_comb begin
    pc_en     = 1'b0;
    if_id_en  = 1'b0;
    stage_en  = 1'b0;
    ex_bubble = 1'b1;
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    state     = StRun;
    if (rst) begin
      fwd_a = fwd_sel(rs1, uses_rs1, ex_q, mem_q, wb_q);
      fwd_b = fwd_sel(rs2, uses_rs2, ex_q, mem_q, wb_q);
      if (mem_wait) begin
        state     = StMemWait;
        ex_bubble = 1'b0;
      end else if (flush) begin
        state     = StFlush;
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        stage_en  = 1'b1;
      end else if (load_stall) begin
        state     = StLoadStall;
        stage_en  = 1'b1;
      end else begin
        state     = StRun;
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        stage_en  = 1'b1;
        ex_bubble = 1'b0;
      end
    end
  end

  always_comb begin
    id_valid_d = id_valid_q;
    if (state == StFlush)    id_valid_d = 1'b0;
    else if (state == StRun) id_valid_d = if_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stage_en) begin
        ex_q  <= '{v: id_valid_q & ~ex_bubble, rd: rd, we: reg_write, ld: load, st: store};
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
      id_valid_q <= id_valid_d;
      if ((state == StLoadStall || state == StMemWait) && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (state == StFlush && flush_cnt_q != {CNT_W{1'b1}}) begin
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // WB load/store flags are carried for debug visibility only.
  logic unused_wb;
  assign unused_wb = ^{wb_q.ld, wb_q.st};

  assign id_valid  = id_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
